apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave_if.sv | 26 ++
 rtl/apb_mem_slave.sv | 123 ++++++++++++
 tb/tb_apb_mem_slave.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle for apb_mem_slave: request signals from the master, registered
// response from the slave.
interface apb_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB word memory with programmable wait states, byte strobes, read-only low
// words and a saturating error-response counter.
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 4
) (
    input  logic              pclk,
    input  logic              preset,
    apb_mem_slave_if.slave    bus,
    output logic [7:0]        err_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [NB-1:0]     strb;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, cur;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] lsb_mask;
    logic              err;
    logic              ld, dec, done, clr;

    // In IDLE the live bus is decoded so a zero-wait transfer can complete on
    // its SETUP edge; afterwards the latched request is used.
    always_comb begin
        if (state_q == IDLE) begin
            cur.addr  = bus.paddr;
            cur.write = bus.pwrite;
            cur.wdata = bus.pwdata;
            cur.strb  = bus.pstrb;
        end else begin
            cur = req_q;
        end
    end

    always_comb begin
        lsb_mask = ADDR_W'((1 << LSB) - 1);
        widx     = cur.addr >> LSB;
        err      = (|(cur.addr & lsb_mask))
                 || ((ADDR_W+1)'(widx) >= (ADDR_W+1)'(DEPTH))
                 || (cur.write && ((ADDR_W+1)'(widx) < (ADDR_W+1)'(RO_WORDS)));
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        dec     = 1'b0;
        done    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = ACCESS;
                    ld      = 1'b1;
                    done    = (WAIT_CYCLES == 0);
                end
            end
            ACCESS: begin
                if (!bus.psel || (bus.penable && bus.pready)) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (bus.penable && !bus.pready && cnt_q != 4'd0) begin
                    dec  = 1'b1;
                    done = (cnt_q == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            req_q       <= '0;
            cnt_q       <= 4'd0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            err_cnt     <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ld) begin
                req_q <= cur;
                cnt_q <= 4'(WAIT_CYCLES);
            end
            if (dec) cnt_q <= cnt_q - 4'd1;
            if (done) begin
                bus.pready  <= 1'b1;
                bus.pslverr <= err;
                bus.prdata  <= (!err && !cur.write) ? mem[widx[IDX_W-1:0]] : '0;
                if (!err && cur.write) begin
                    for (int b = 0; b < NB; b++)
                        if (cur.strb[b]) mem[widx[IDX_W-1:0]][b*8 +: 8] <= cur.wdata[b*8 +: 8];
                end
                if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            if (clr) begin
                bus.pready  <= 1'b0;
                bus.pslverr <= 1'b0;
                bus.prdata  <= '0;
                cnt_q       <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a zero-wait and a two-wait instance share one bus
// driver and are checked against an array model of the memory rules.
module tb_apb_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [7:0]  ec0, ec2;

    always #5 clk = ~clk;

    apb_mem_slave_if #(.DATA_W(32), .ADDR_W(12)) if0 ();
    apb_mem_slave_if #(.DATA_W(32), .ADDR_W(12)) if2 ();

    assign if0.psel = psel & ~sel;
    assign if2.psel = psel & sel;
    assign if0.penable = penable; assign if2.penable = penable;
    assign if0.pwrite  = pwrite;  assign if2.pwrite  = pwrite;
    assign if0.paddr   = paddr;   assign if2.paddr   = paddr;
    assign if0.pwdata  = pwdata;  assign if2.pwdata  = pwdata;
    assign if0.pstrb   = pstrb;   assign if2.pstrb   = pstrb;

    apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0), .RO_WORDS(4))
        dut0 (.pclk(clk), .preset(rst), .bus(if0), .err_cnt(ec0));
    apb_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(2), .RO_WORDS(4))
        dut2 (.pclk(clk), .preset(rst), .bus(if2), .err_cnt(ec2));

    wire [31:0] o_rdata = sel ? if2.prdata  : if0.prdata;
    wire        o_ready = sel ? if2.pready  : if0.pready;
    wire        o_err   = sel ? if2.pslverr : if0.pslverr;
    wire [7:0]  o_cnt   = sel ? ec2 : ec0;

    int checks = 0;
    int errors = 0;

    // Reference model: one word array and error counter per instance.
    logic [31:0] mdl [2][256];
    int          mcnt [2];

    task automatic clear_model();
        for (int w = 0; w < 2; w++) begin
            mcnt[w] = 0;
            for (int i = 0; i < 256; i++) mdl[w][i] = 32'h0;
        end
    endtask

    task automatic model_xfer(input int w, input logic [11:0] a, input logic wr,
                              input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rd, output logic er);
        int idx;
        idx = int'(a) / 4;
        er  = (int'(a) % 4 != 0) || (idx >= 256) || (wr && idx < 4);
        rd  = 32'h0;
        if (er) begin
            if (mcnt[w] < 255) mcnt[w]++;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[w][idx][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            rd = mdl[w][idx];
        end
    endtask

    // Drives one transfer starting just after an edge and leaves the bus idle
    // just after the completion edge, so consecutive calls are back-to-back.
    task automatic xfer(input logic [11:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int waits);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!o_ready && waits < 40) begin
            checks++;
            if (o_err !== 1'b0 || o_rdata !== 32'h0) begin
                errors++;
                $display("FAIL wait_outputs addr=%h pslverr=%b prdata=%h, required 0/0", a, o_err, o_rdata);
            end
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL pready_timeout addr=%h pready=%b after %0d cycles, required 1", a, o_ready, waits);
        end
        rd = o_rdata;
        er = o_err;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL post_complete pready=%b pslverr=%b prdata=%h, required 0/0/0", o_ready, o_err, o_rdata);
        end
    endtask

    task automatic run(input int w, input logic [11:0] a, input logic wr, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int wt, output logic [31:0] erd, output logic eer);
        sel = (w != 0);
        xfer(a, wr, d, s, rd, er, wt);
        model_xfer(w, a, wr, d, s, erd, eer);
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if0.pready, if0.pslverr, if0.prdata, ec0, if2.pready, if2.pslverr, if2.prdata, ec2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs d0=%b/%b/%h/%0d d2=%b/%b/%h/%0d, required all 0",
                     if0.pready, if0.pslverr, if0.prdata, ec0, if2.pready, if2.pslverr, if2.prdata, ec2);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, erd; logic er, eer; int wt;
        run(0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, wt, erd, eer);
        checks++;
        if (er !== 1'b0 || wt != 0) begin
            errors++;
            $display("FAIL zw_write pslverr=%b waits=%0d, required 0/0", er, wt);
        end
        run(0, 12'h010, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'hDEADBEEF || rd !== erd || er !== 1'b0 || wt != 0) begin
            errors++;
            $display("FAIL zw_read prdata=%h pslverr=%b waits=%0d, required DEADBEEF/0/0", rd, er, wt);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, erd; logic er, eer; int wt;
        run(1, 12'h020, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (wt != 2 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws_read waits=%0d prdata=%h pslverr=%b, required 2/0/0", wt, rd, er);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, erd; logic er, eer; int wt;
        run(1, 12'h030, 1'b1, 32'hAABBCCDD, 4'hF, rd, er, wt, erd, eer);
        run(1, 12'h030, 1'b1, 32'h11223344, 4'h5, rd, er, wt, erd, eer);
        run(1, 12'h030, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'hAA22CC44 || rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL strobe_merge prdata=%h pslverr=%b, required AA22CC44/0", rd, er);
        end
        run(1, 12'h030, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL strobe_zero_resp pslverr=%b, required 0", er);
        end
        run(1, 12'h030, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL strobe_zero_data prdata=%h, required AA22CC44", rd);
        end
    endtask

    task automatic test_errors();
        logic [11:0] ea [3];
        logic        ew [3];
        logic [31:0] rd, erd; logic er, eer; int wt;
        ea = '{12'h008, 12'h400, 12'h013};
        ew = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run(0, ea[i], ew[i], 32'hCAFEF00D, 4'hF, rd, er, wt, erd, eer);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || er !== eer) begin
                errors++;
                $display("FAIL err_resp addr=%h pslverr=%b prdata=%h, required 1/0", ea[i], er, rd);
            end
        end
        checks++;
        if (o_cnt !== 8'd3 || int'(o_cnt) != mcnt[0]) begin
            errors++;
            $display("FAIL err_cnt_three err_cnt=%0d, required 3", o_cnt);
        end
        run(0, 12'h008, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (er !== 1'b0 || rd !== erd) begin
            errors++;
            $display("FAIL ro_read pslverr=%b prdata=%h, required 0/%h", er, rd, erd);
        end
    endtask

    task automatic test_idle_enable();
        logic [31:0] rd, erd; logic er, eer; int wt;
        sel = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h0; pstrb = 4'hF;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (o_ready !== 1'b0 || o_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_enable pready=%b pslverr=%b, required 0/0", o_ready, o_err);
            end
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        run(1, 12'h030, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL idle_enable_mem prdata=%h, required %h", rd, erd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic er, eer; int wt;
        sel = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_ready !== 1'b0 || o_err !== 1'b0 || o_cnt !== 8'(mcnt[1])) begin
            errors++;
            $display("FAIL abort_resp pready=%b pslverr=%b err_cnt=%0d, required 0/0/%0d", o_ready, o_err, o_cnt, mcnt[1]);
        end
        run(1, 12'h040, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_mem prdata=%h, required 0", rd);
        end
        // Reset lands in the middle of the wait states of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h044; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        checks++;
        if ({if0.pready, if0.pslverr, if0.prdata, ec0, if2.pready, if2.pslverr, if2.prdata, ec2} !== '0) begin
            errors++;
            $display("FAIL async_reset d2=%b/%b/%h/%0d d0 cnt=%0d, required all 0",
                     if2.pready, if2.pslverr, if2.prdata, ec2, ec0);
        end
        psel = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        run(1, 12'h044, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_write prdata=%h, required 0", rd);
        end
        run(1, 12'h040, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_0x040 prdata=%h, required 0", rd);
        end
        run(0, 12'h010, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (rd !== 32'h0 || ec0 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mem_clear prdata=%h err_cnt=%0d, required 0/0", rd, ec0);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, d; logic er, eer, wr; int wt, w;
        logic [11:0] a; logic [3:0] s;
        for (int i = 0; i < 150; i++) begin
            w  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            s  = 4'($urandom);
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            else                           a = 12'($urandom_range(0, 15)) << 2;
            run(w, a, wr, d, s, rd, er, wt, erd, eer);
            checks++;
            if (rd !== erd || er !== eer || wt != (w == 0 ? 0 : 2) || int'(o_cnt) != mcnt[w]) begin
                errors++;
                $display("FAIL random inst=%0d addr=%h wr=%b prdata=%h pslverr=%b waits=%0d err_cnt=%0d, required %h/%b/%0d/%0d",
                         w, a, wr, rd, er, wt, o_cnt, erd, eer, (w == 0 ? 0 : 2), mcnt[w]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd, erd; logic er, eer; int wt;
        for (int i = 0; i < 256; i++)
            run(0, 12'h000, 1'b1, 32'h0, 4'hF, rd, er, wt, erd, eer);
        checks++;
        if (ec0 !== 8'd255 || mcnt[0] != 255) begin
            errors++;
            $display("FAIL err_cnt_sat err_cnt=%0d, required 255", ec0);
        end
        run(0, 12'h013, 1'b0, 32'h0, 4'h0, rd, er, wt, erd, eer);
        checks++;
        if (ec0 !== 8'd255 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_cnt_hold err_cnt=%0d pslverr=%b, required 255/1", ec0, er);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_strobe();
        test_errors();
        test_idle_enable();
        test_abort();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
